bar_foo_handshake_arbiter: RTL and testbench
============================================

// Module: bar_foo_handshake_arbiter
// PURPOSE
//  Round-robin N:1 ready/valid arbiter feeding the single handshake port of bar_foo_RTL.
//  Merges the handshake_arr_* request channels into one registered output channel, with source index.
//  Its output is the handshake stream bar_foo_RTLMonitor checks; full throughput, no data loss.
// PARAMETERS
//  N_PORTS  3  number of upstream request channels (>=2)
//  WIDTH    4  payload width per channel
// PORTS
//  CLK                  in   1                 clock, all logic on posedge
//  RESET                in   1                 synchronous, active-high reset
//  handshake_arr_valid  in   N_PORTS           per-channel valid
//  handshake_arr_data   in   N_PORTS x WIDTH   per-channel payload (packed array [N_PORTS-1:0][WIDTH-1:0])
//  handshake_arr_ready  out  N_PORTS           per-channel ready (one-hot or zero)
//  handshake_valid      out  1                 output valid (registered)
//  handshake_data       out  WIDTH             output payload (registered)
//  handshake_src        out  SRC_W             index of channel that produced current output
//  handshake_ready      in   1                 downstream ready
// BEHAVIOUR
//  - Reset (RESET=1 at posedge): handshake_valid=0, handshake_data=0, handshake_src=0, rr pointer=0.
//    RESET overrides any in-flight beat; the held output beat is dropped; arbitration restarts at port 0.
//  - Output slot accepts when can_load = ~handshake_valid | handshake_ready (combinational path from handshake_ready).
//  - Arbitration: among valid channels, grant first index at or after rr pointer (mod N_PORTS).
//  - handshake_arr_ready[i] = grant[i] & can_load; at most one bit set; all zero when no valid or ~can_load.
//  - Upstream transfer on channel i (valid[i]&ready[i]): next cycle handshake_valid=1, data=arr_data[i], src=i;
//    rr pointer <= (i+1) mod N_PORTS. Pointer unchanged on cycles with no upstream transfer.
//  - Latency 1 cycle input->output; throughput 1 beat/cycle with handshake_ready held high.
//  - Output hold: while handshake_valid & ~handshake_ready, data/src/valid stable; all upstream ready=0.
//  - Simultaneous drain+load (valid&ready downstream, upstream transfer same cycle): output replaced, valid stays 1.
//  - Drain without load: handshake_valid -> 0; data/src hold last value.
//  - Wrap-around: grant at N_PORTS-1 sets pointer to 0. Single valid channel is granted every eligible cycle.
//  - Fairness: a continuously valid channel waits at most N_PORTS-1 transfers.
//  - Upstream channels obey ready/valid: valid may not drop and data must hold until ready.
// CONFIGURATION
//  BAR_FOO_HANDSHAKE_ARB_ASSERT_EN defined: concurrent SVA on CLK, disabled iff RESET:
//    $onehot0(handshake_arr_ready); output stability under backpressure (valid/data/src);
//    upstream valid&~ready |=> valid stable and data stable; no X on handshake_valid after reset.
//  Undefined: no assertions compiled; RTL behaviour identical.
// STRUCTURE
//  Package bar_foo_arb_pkg: SRC_W = $clog2(N_PORTS) helper function, typedef src_t,
//    typedef payload_t logic [WIDTH-1:0], reset constants (RR_RESET=0).
//  Sub-module bar_foo_rr_pick: combinational rotate-priority picker (valid vector + pointer -> one-hot grant, index).
//  Top holds output register, pointer register, ready generation, optional assertions.
// TESTING
//  1. RESET high 2 cycles -> handshake_valid=0, data=0, src=0, arr_ready=000 while held.
//  2. valid=111, data={C,B,A}, handshake_ready=1 constant -> outputs A,B,C,A,... src 0,1,2,0; one beat/cycle.
//  3. valid=101 only, ready=1 -> src sequence 0,2,0,2; channel 1 never granted; pointer wraps 2->0.
//  4. valid=010 data=5, handshake_ready=0 for 3 cycles after first load -> data=5, src=1 held, arr_ready=000;
//     ready=1 -> next beat accepted same cycle, valid stays 1.
//  5. Drain with no upstream valid -> handshake_valid 1->0, data keeps last value.
//  6. RESET asserted while handshake_valid=1 and backpressured -> next cycle valid=0, src=0; next grant to port 0.

Source files
------------

// File: rtl/bar_foo_arb_pkg.sv
// ============================================================================
// Module : bar_foo_arb_pkg
// Brief  : Shared types and constants for the bar_foo handshake arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bar_foo_arb_pkg;

  localparam int C_N_PORTS = 3;
  localparam int C_WIDTH   = 4;
  localparam int RR_RESET  = 0;

  // Index width, kept at least one bit wide so degenerate configs still elaborate.
  function automatic int src_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int C_SRC_W = src_width(C_N_PORTS);

  typedef logic [C_SRC_W-1:0] src_t;
  typedef logic [C_WIDTH-1:0] payload_t;

endpackage

`default_nettype wire

// File: rtl/bar_foo_rr_pick.sv
// ============================================================================
// Module : bar_foo_rr_pick
// Brief  : Combinational rotate-priority picker: first valid at/after pointer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bar_foo_rr_pick
  import bar_foo_arb_pkg::*;
#(
  parameter int N_PORTS = C_N_PORTS,
  parameter int SRC_W   = src_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] valid,
  input  logic [SRC_W-1:0]   ptr,
  output logic [N_PORTS-1:0] grant,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

  logic [SRC_W-1:0] w_cand;

  // Scan from farthest offset down so the nearest valid channel is written last.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      w_cand = SRC_W'((int'(ptr) + k) % N_PORTS);
      if (valid[w_cand]) begin
        grant         = '0;
        grant[w_cand] = 1'b1;
        idx           = w_cand;
        any           = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bar_foo_handshake_arbiter.sv
// ============================================================================
// Module : bar_foo_handshake_arbiter
// Brief  : Round-robin N:1 ready/valid arbiter with registered output slot.
//          Optional checkers: define BAR_FOO_HANDSHAKE_ARB_ASSERT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bar_foo_handshake_arbiter
  import bar_foo_arb_pkg::*;
#(
  parameter int N_PORTS = C_N_PORTS,
  parameter int WIDTH   = C_WIDTH,
  parameter int SRC_W   = src_width(N_PORTS)
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [N_PORTS-1:0]               handshake_arr_valid,
  input  logic [N_PORTS-1:0][WIDTH-1:0]    handshake_arr_data,
  output logic [N_PORTS-1:0]               handshake_arr_ready,
  output logic                             handshake_valid,
  output logic [WIDTH-1:0]                 handshake_data,
  output logic [SRC_W-1:0]                 handshake_src,
  input  logic                             handshake_ready
);

  logic               r_valid;
  logic [WIDTH-1:0]   r_data;
  logic [SRC_W-1:0]   r_src;
  logic [SRC_W-1:0]   r_ptr;

  logic [N_PORTS-1:0] w_grant;
  logic [SRC_W-1:0]   w_idx;
  logic               w_any;
  logic               w_can_load;
  logic               w_xfer;

  bar_foo_rr_pick #(
    .N_PORTS (N_PORTS),
    .SRC_W   (SRC_W)
  ) u_pick (
    .valid (handshake_arr_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  // Slot is free when empty or being drained this cycle; reset blocks all grants.
  assign w_can_load          = ~r_valid | handshake_ready;
  assign w_xfer              = w_any & w_can_load & ~RESET;
  assign handshake_arr_ready = (w_can_load & ~RESET) ? w_grant : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= SRC_W'(RR_RESET);
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= handshake_arr_data[w_idx];
      r_src   <= w_idx;
      r_ptr   <= (w_idx == SRC_W'(N_PORTS - 1)) ? '0 : w_idx + SRC_W'(1);
    end else if (handshake_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign handshake_valid = r_valid;
  assign handshake_data  = r_data;
  assign handshake_src   = r_src;

`ifdef BAR_FOO_HANDSHAKE_ARB_ASSERT_EN
  a_ready_onehot0: assert property (@(posedge CLK) disable iff (RESET)
    $onehot0(handshake_arr_ready));

  a_out_hold: assert property (@(posedge CLK) disable iff (RESET)
    handshake_valid & ~handshake_ready |=>
      handshake_valid & $stable(handshake_data) & $stable(handshake_src));

  a_valid_known: assert property (@(posedge CLK) disable iff (RESET)
    !$isunknown(handshake_valid));

  for (genvar g = 0; g < N_PORTS; g++) begin : g_up_chk
    a_up_stable: assert property (@(posedge CLK) disable iff (RESET)
      handshake_arr_valid[g] & ~handshake_arr_ready[g] |=>
        handshake_arr_valid[g] & $stable(handshake_arr_data[g]));
  end
`else
  // Checkers not compiled in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_bar_foo_handshake_arbiter.sv
// ============================================================================
// Module : tb_bar_foo_handshake_arbiter
// Brief  : Directed self-checking bench for the round-robin handshake arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bar_foo_handshake_arbiter;

  localparam int N_PORTS = 3;
  localparam int WIDTH   = 4;
  localparam int SRC_W   = 2;

  logic                          CLK = 1'b0;
  logic                          RESET;
  logic [N_PORTS-1:0]            arr_valid;
  logic [N_PORTS-1:0][WIDTH-1:0] arr_data;
  logic [N_PORTS-1:0]            arr_ready;
  logic                          hs_valid;
  logic [WIDTH-1:0]              hs_data;
  logic [SRC_W-1:0]              hs_src;
  logic                          hs_ready;

  int n_checks = 0;
  int n_fail   = 0;

  bar_foo_handshake_arbiter #(
    .N_PORTS (N_PORTS),
    .WIDTH   (WIDTH)
  ) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .handshake_arr_valid (arr_valid),
    .handshake_arr_data  (arr_data),
    .handshake_arr_ready (arr_ready),
    .handshake_valid     (hs_valid),
    .handshake_data      (hs_data),
    .handshake_src       (hs_src),
    .handshake_ready     (hs_ready)
  );

  always #5 CLK = ~CLK;

  // Observed vector layout: {valid, data[3:0], src[1:0], arr_ready[2:0]}
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET     = 1'b1;
    arr_valid = 3'b111;
    arr_data  = {4'hC, 4'hB, 4'hA};
    hs_ready  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if ({hs_valid, hs_data, hs_src, arr_ready} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %b required %b", k,
                 {hs_valid, hs_data, hs_src, arr_ready}, 10'b0);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] exp_d;
    logic [2:0]       exp_r;
    RESET = 1'b0;
    #1;
    n_checks++;
    if ({hs_valid, arr_ready} !== 4'b0_001) begin
      n_fail++;
      $display("FAIL rr_first_grant: got %b required %b", {hs_valid, arr_ready}, 4'b0_001);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_d = (k % 3 == 0) ? 4'hA : (k % 3 == 1) ? 4'hB : 4'hC;
      exp_r = 3'b001 << ((k + 1) % 3);
      n_checks++;
      if ({hs_valid, hs_data, hs_src, arr_ready} !== {1'b1, exp_d, 2'(k % 3), exp_r}) begin
        n_fail++;
        $display("FAIL rr_beat[%0d]: got %b required %b", k,
                 {hs_valid, hs_data, hs_src, arr_ready}, {1'b1, exp_d, 2'(k % 3), exp_r});
      end
    end
  endtask

  task automatic test_skip_idle();
    logic [WIDTH-1:0] exp_d;
    logic [SRC_W-1:0] exp_s;
    logic [2:0]       exp_r;
    arr_valid = 3'b101;
    #1;
    n_checks++;
    if (arr_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL skip_first_grant: got %b required %b", arr_ready, 3'b001);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_s = (k % 2 == 1) ? 2'd2 : 2'd0;
      exp_d = (k % 2 == 1) ? 4'hC : 4'hA;
      exp_r = (k % 2 == 1) ? 3'b001 : 3'b100;
      n_checks++;
      if ({hs_valid, hs_data, hs_src, arr_ready} !== {1'b1, exp_d, exp_s, exp_r}) begin
        n_fail++;
        $display("FAIL skip_beat[%0d]: got %b required %b", k,
                 {hs_valid, hs_data, hs_src, arr_ready}, {1'b1, exp_d, exp_s, exp_r});
      end
    end
  endtask

  task automatic test_backpressure();
    arr_valid   = 3'b010;
    arr_data[1] = 4'h5;
    #1;
    n_checks++;
    if (arr_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_grant: got %b required %b", arr_ready, 3'b010);
    end
    tick();
    hs_ready    = 1'b0;
    arr_data[1] = 4'h6;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({hs_valid, hs_data, hs_src, arr_ready} !== {1'b1, 4'h5, 2'd1, 3'b000}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got %b required %b", k,
                 {hs_valid, hs_data, hs_src, arr_ready}, {1'b1, 4'h5, 2'd1, 3'b000});
      end
      if (k < 3) tick();
    end
    hs_ready = 1'b1;
    #1;
    n_checks++;
    if (arr_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b required %b", arr_ready, 3'b010);
    end
    tick();
    n_checks++;
    if ({hs_valid, hs_data, hs_src, arr_ready} !== {1'b1, 4'h6, 2'd1, 3'b010}) begin
      n_fail++;
      $display("FAIL bp_drain_load: got %b required %b",
               {hs_valid, hs_data, hs_src, arr_ready}, {1'b1, 4'h6, 2'd1, 3'b010});
    end
  endtask

  task automatic test_drain();
    arr_valid = 3'b000;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if ({hs_valid, hs_data, hs_src, arr_ready} !== {1'b0, 4'h6, 2'd1, 3'b000}) begin
        n_fail++;
        $display("FAIL drain[%0d]: got %b required %b", k,
                 {hs_valid, hs_data, hs_src, arr_ready}, {1'b0, 4'h6, 2'd1, 3'b000});
      end
    end
  endtask

  task automatic test_reset_midflight();
    // Grant port 0 first so the pointer sits at 1 when reset hits.
    arr_valid = 3'b001;
    arr_data  = {4'hC, 4'hB, 4'h7};
    tick();
    n_checks++;
    if ({hs_valid, hs_data, hs_src} !== {1'b1, 4'h7, 2'd0}) begin
      n_fail++;
      $display("FAIL rst_pre_load: got %b required %b",
               {hs_valid, hs_data, hs_src}, {1'b1, 4'h7, 2'd0});
    end
    hs_ready  = 1'b0;
    arr_valid = 3'b111;
    #1;
    n_checks++;
    if (arr_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_pre_bp: got %b required %b", arr_ready, 3'b000);
    end
    RESET = 1'b1;
    tick();
    n_checks++;
    if ({hs_valid, hs_data, hs_src, arr_ready} !== 10'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got %b required %b",
               {hs_valid, hs_data, hs_src, arr_ready}, 10'b0);
    end
    RESET    = 1'b0;
    hs_ready = 1'b1;
    arr_data = {4'hC, 4'hB, 4'hA};
    #1;
    n_checks++;
    if (arr_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL rst_ptr_restart: got %b required %b", arr_ready, 3'b001);
    end
    tick();
    n_checks++;
    if ({hs_valid, hs_data, hs_src, arr_ready} !== {1'b1, 4'hA, 2'd0, 3'b010}) begin
      n_fail++;
      $display("FAIL rst_first_beat: got %b required %b",
               {hs_valid, hs_data, hs_src, arr_ready}, {1'b1, 4'hA, 2'd0, 3'b010});
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_skip_idle();
    test_backpressure();
    test_drain();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
